// File: rtl/pcie_intr_sched.sv
// -----------------------------------------------------------------------------
// pcie_intr_sched
//
// Interrupt scheduler placed in front of the PCIe interrupt generator.
//
// Per-source event pulses are latched into a pending register. A coalescing
// phase waits for either enough events or a timeout. The pending set is then
// frozen into a snapshot and presented as a stable factor vector. Once software
// has write-1-cleared every snapshot bit, a one-cycle clear pulse goes to the
// generator. A programmable idle gap follows before the next round can start.
//
// Ports
//   PCIE_CLK   : clock
//   PCIE_RST   : asynchronous, active-high reset
//   EN         : scheduler enable. Low aborts any round in progress.
//   SRC_EVT    : per-source one-cycle event pulses
//   MASK       : 1 = source masked (its events are not latched)
//   COAL_CNT   : event-count threshold (0 or 1 = no count coalescing)
//   COAL_TMR   : coalescing timeout in cycles (0 = immediate)
//   GAP_CYC    : idle cycles enforced after each INTR_CLR
//   ACK_VLD    : software acknowledge strobe
//   ACK_DATA   : write-1-to-clear bits for the pending register
//   INTR_FACT  : factor vector to the interrupt generator
//   INTR_CLR   : one-cycle clear pulse to the interrupt generator
//   PEND       : pending register readback
//   BUSY       : scheduler not idle
//   INTR_CNT   : saturating count of rounds issued
//   DBG_STATE  : one-hot FSM state, for debug and checker binding
//
// Handshake: ACK_VLD is a plain strobe with no ready. The block accepts every
// cycle in which ACK_VLD is high, and ACK_DATA is only looked at in that cycle.
// -----------------------------------------------------------------------------
module pcie_intr_sched #(
   parameter int N_SRC = 8,
   parameter int TMR_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             PCIE_CLK,
   input  logic             PCIE_RST,
   input  logic             EN,
   input  logic [N_SRC-1:0] SRC_EVT,
   input  logic [N_SRC-1:0] MASK,
   input  logic [CNT_W-1:0] COAL_CNT,
   input  logic [TMR_W-1:0] COAL_TMR,
   input  logic [TMR_W-1:0] GAP_CYC,
   input  logic             ACK_VLD,
   input  logic [N_SRC-1:0] ACK_DATA,
   output logic [N_SRC-1:0] INTR_FACT,
   output logic             INTR_CLR,
   output logic [N_SRC-1:0] PEND,
   output logic             BUSY,
   output logic [15:0]      INTR_CNT,
   output logic [3:0]       DBG_STATE
);

   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_COAL   = 4'b0010,
      ST_ACTIVE = 4'b0100,
      ST_GAP    = 4'b1000
   } state_t;

   state_t           state_q;
   logic [N_SRC-1:0] pend_q;
   logic [N_SRC-1:0] pend_d;
   logic [N_SRC-1:0] snap_q;
   logic [N_SRC-1:0] fact_q;
   logic             clr_q;
   logic [TMR_W-1:0] tmr_q;
   logic [TMR_W-1:0] gap_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] thr_q;
   logic [15:0]      intr_cnt_q;

   logic [N_SRC-1:0] evt_vec;
   logic [N_SRC-1:0] ack_vec;
   logic             new_evt;

   // Unmasked events for this cycle. Masking only blocks new sets. It never
   // clears a bit that is already pending.
   assign evt_vec = SRC_EVT & ~MASK;
   assign ack_vec = ACK_VLD ? ACK_DATA : '0;
   assign new_evt = |evt_vec;

   // A set wins over a simultaneous W1C clear, so a re-firing source is never lost.
   assign pend_d = (pend_q & ~ack_vec) | evt_vec;

   always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
      if (PCIE_RST) begin
         state_q    <= ST_IDLE;
         pend_q     <= '0;
         snap_q     <= '0;
         fact_q     <= '0;
         clr_q      <= 1'b0;
         tmr_q      <= '0;
         gap_q      <= '0;
         cnt_q      <= '0;
         thr_q      <= '0;
         intr_cnt_q <= '0;
      end else begin
         pend_q <= pend_d;
         clr_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // Coalescing parameters are captured here, so that changes
               // made during a round only apply to the next round.
               if (EN && (pend_q != '0)) begin
                  state_q <= ST_COAL;
                  tmr_q   <= COAL_TMR;
                  thr_q   <= COAL_CNT;
                  cnt_q   <= CNT_W'(1);
               end
            end

            ST_COAL: begin
               if (!EN) begin
                  state_q <= ST_IDLE;
               end else if ((cnt_q >= thr_q) || (tmr_q == '0)) begin
                  // The snapshot includes events that arrive on this same edge.
                  state_q <= ST_ACTIVE;
                  snap_q  <= pend_d;
                  fact_q  <= pend_d;
                  if (intr_cnt_q != 16'hFFFF) begin
                     intr_cnt_q <= intr_cnt_q + 16'd1;
                  end
               end else begin
                  tmr_q <= tmr_q - TMR_W'(1);
                  if (new_evt && (cnt_q != '1)) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end

            ST_ACTIVE: begin
               if (!EN) begin
                  // Abort: the generator still gets its clear, but no gap follows.
                  clr_q   <= 1'b1;
                  fact_q  <= '0;
                  snap_q  <= '0;
                  state_q <= ST_IDLE;
               end else if ((pend_d & snap_q) == '0) begin
                  // The round closes on the edge that clears the last snapshot bit.
                  clr_q   <= 1'b1;
                  fact_q  <= '0;
                  snap_q  <= '0;
                  gap_q   <= GAP_CYC;
                  state_q <= ST_GAP;
               end
            end

            ST_GAP: begin
               if (!EN || (gap_q == '0)) begin
                  state_q <= ST_IDLE;
               end else begin
                  gap_q <= gap_q - TMR_W'(1);
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign INTR_FACT = fact_q;
   assign INTR_CLR  = clr_q;
   assign PEND      = pend_q;
   assign BUSY      = (state_q != ST_IDLE);
   assign INTR_CNT  = intr_cnt_q;
   assign DBG_STATE = state_q;

endmodule
